// File: rtl/formant_excitation_pkg.sv
// Shared types and constants for the formant excitation source.
package formant_excitation_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/formant_excitation_lfsr16.sv
// 16-bit right-shifting Galois LFSR used as the unvoiced noise source.
module lfsr16
  import formant_excitation_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (step) value_d = (value_q >> 1) ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value_q <= LFSR_SEED;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/formant_excitation.sv
// Sample-rate excitation source for a formant filter: tick divider, sawtooth/noise
// source, and an attack/sustain/release envelope scaling an offset-binary output.
module formant_excitation
  import formant_excitation_pkg::*;
#(
  parameter int outputwidth = 16,
  parameter int clkdiv      = 1134,
  parameter int phasewidth  = 24,
  parameter int envwidth    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   gate,
  input  logic                   voiced,
  input  logic [phasewidth-1:0]  pitch_inc,
  output logic                   ena,
  output logic [outputwidth-1:0] q
);

  localparam int DW = $clog2(clkdiv);
  localparam int PW = outputwidth + envwidth + 1;
  localparam logic [DW-1:0]          DIV_LAST = DW'(clkdiv - 1);
  localparam logic [outputwidth-1:0] MID      = outputwidth'(midscale(outputwidth));
  localparam logic [envwidth-1:0]    ENV_MAX  = '1;
  localparam logic [envwidth-1:0]    ENV_ONE  = envwidth'(1);

  logic [DW-1:0]          div_q, div_d;
  logic                   ena_q;
  logic [outputwidth-1:0] q_q, q_d;
  logic [phasewidth-1:0]  phase_q, phase_d;
  logic [envwidth-1:0]    env_q, env_d;
  env_state_e             state_q, state_d;
  logic [15:0]            lfsr_val;
  logic                   tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  lfsr16 u_lfsr (
    .clk    (clk),
    .reset_n(reset_n),
    .step   (tick),
    .value  (lfsr_val)
  );

  // Scaler: signed source times unsigned envelope, arithmetic shift back down.
  logic [outputwidth-1:0] src, s;
  logic signed [PW-1:0]   s_ext, e_ext, prod;
  logic                   unused_prod_bits;

  always_comb begin
    src   = voiced ? phase_q[phasewidth-1 -: outputwidth] : lfsr_val[outputwidth-1:0];
    s     = src - MID;
    s_ext = {{(envwidth+1){s[outputwidth-1]}}, s};
    e_ext = {{(outputwidth+1){1'b0}}, env_q};
    prod  = s_ext * e_ext;
    q_d   = MID + prod[envwidth +: outputwidth];
  end

  assign unused_prod_bits = ^{prod[PW-1], prod[envwidth-1:0]};
  assign phase_d = phase_q + pitch_inc;

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (tick) begin
      unique case (state_q)
        ENV_IDLE:    if (gate) state_d = ENV_ATTACK;
        ENV_ATTACK: begin
          if (!gate)                  state_d = ENV_RELEASE;
          else if (env_q == ENV_MAX)  state_d = ENV_SUSTAIN;
          else begin
            env_d = env_q + ENV_ONE;
            if (env_q == ENV_MAX - ENV_ONE) state_d = ENV_SUSTAIN;
          end
        end
        ENV_SUSTAIN: if (!gate) state_d = ENV_RELEASE;
        ENV_RELEASE: begin
          // Retrigger resumes from the current level rather than restarting at 0.
          if (gate)              state_d = ENV_ATTACK;
          else if (env_q == '0)  state_d = ENV_IDLE;
          else begin
            env_d = env_q - ENV_ONE;
            if (env_q == ENV_ONE) state_d = ENV_IDLE;
          end
        end
        default: state_d = ENV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      ena_q   <= 1'b0;
      q_q     <= MID;
      phase_q <= '0;
      env_q   <= '0;
      state_q <= ENV_IDLE;
    end else begin
      div_q   <= div_d;
      ena_q   <= tick;
      state_q <= state_d;
      env_q   <= env_d;
      if (tick) begin
        q_q     <= q_d;
        phase_q <= phase_d;
      end
    end
  end

  assign ena = ena_q;
  assign q   = q_q;

endmodule

// File: tb/tb_formant_excitation.sv
// Directed bench for formant_excitation with a short divider (clkdiv = 4).
module tb_formant_excitation;
  import formant_excitation_pkg::*;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        gate = 1'b0;
  logic        voiced = 1'b0;
  logic [23:0] pitch_inc = '0;
  logic        ena;
  logic [15:0] q;

  int tests = 0;
  int fails = 0;

  formant_excitation #(
    .outputwidth(16), .clkdiv(CD), .phasewidth(24), .envwidth(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .gate(gate), .voiced(voiced),
    .pitch_inc(pitch_inc), .ena(ena), .q(q)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  function automatic logic [15:0] scale_exp(input logic [15:0] src, input int env);
    int s, p;
    s = int'(src) - 32768;
    p = s * env;
    return 16'(32768 + (p >>> 8));
  endfunction

  task automatic wait_ena();
    bit ok;
    ok = 0;
    for (int i = 0; i < 3*CD; i++) begin
      @(posedge clk); #1;
      if (ena) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL ena_timeout: no ena within %0d clocks", 3*CD);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic exp;
    do_reset();
    gate = 1; voiced = 0; pitch_inc = 24'h012345;
    repeat (40) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    tests++; if (ena !== 1'b0) begin fails++; $display("FAIL reset_ena: got %b want 0", ena); end
    tests++; if (q !== 16'h8000) begin fails++; $display("FAIL reset_q: got %h want 8000", q); end
    tests++; if (dut.env_q !== 8'd0 || dut.state_q !== ENV_IDLE) begin
      fails++; $display("FAIL reset_env: got env %0d state %0d want 0/IDLE", dut.env_q, dut.state_q);
    end
    gate = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      exp = (c % 4 == 0);
      tests++;
      if (ena !== exp) begin fails++; $display("FAIL strobe_clk%0d: got %b want %b", c, ena, exp); end
    end
  endtask

  task automatic test_lfsr();
    logic [15:0] exp [3];
    exp = '{16'hE270, 16'h7138, 16'h389C};
    do_reset();
    voiced = 0; gate = 1; pitch_inc = '0;
    for (int t = 0; t < 3; t++) begin
      wait_ena();
      tests++;
      if (dut.u_lfsr.value !== exp[t]) begin
        fails++; $display("FAIL lfsr_tick%0d: got %h want %h", t+1, dut.u_lfsr.value, exp[t]);
      end
      if (t == 0) begin
        tests++;
        if (q !== 16'h8000) begin fails++; $display("FAIL lfsr_q_env0: got %h want 8000", q); end
      end
    end
  endtask

  task automatic test_attack_saw();
    int n;
    logic [15:0] exp;
    do_reset();
    voiced = 1; gate = 1; pitch_inc = 24'h100000;
    n = 0;
    while (dut.env_q != 8'd255 && n < 300) begin wait_ena(); n++; end
    tests++; if (n != 256) begin fails++; $display("FAIL attack_ticks: got %0d want 256", n); end
    tests++; if (dut.state_q !== ENV_SUSTAIN) begin
      fails++; $display("FAIL attack_sustain: got state %0d want %0d", dut.state_q, ENV_SUSTAIN);
    end
    for (int k = 0; k < 32; k++) begin
      wait_ena();
      exp = scale_exp(16'((k % 16) * 32'h1000), 255);
      tests++;
      if (q !== exp) begin fails++; $display("FAIL saw_tick%0d: got %h want %h", k, q, exp); end
      if (k == 12) begin
        tests++;
        if (q !== 16'hBFC0) begin fails++; $display("FAIL saw_c00000: got %h want bfc0", q); end
      end
    end
  endtask

  task automatic test_release();
    int n;
    do_reset();
    voiced = 1; gate = 1; pitch_inc = '0;
    n = 0;
    while (dut.env_q != 8'd100 && n < 250) begin wait_ena(); n++; end
    tests++; if (dut.state_q !== ENV_ATTACK) begin
      fails++; $display("FAIL rel_pre_state: got %0d want ATTACK", dut.state_q);
    end
    gate = 0;
    wait_ena();
    tests++; if (dut.state_q !== ENV_RELEASE || dut.env_q !== 8'd100) begin
      fails++; $display("FAIL rel_enter: got state %0d env %0d want RELEASE/100", dut.state_q, dut.env_q);
    end
    n = 0;
    while (dut.env_q != 8'd0 && n < 150) begin wait_ena(); n++; end
    tests++; if (n != 100) begin fails++; $display("FAIL rel_ticks: got %0d want 100", n); end
    tests++; if (dut.state_q !== ENV_IDLE) begin
      fails++; $display("FAIL rel_idle: got state %0d want IDLE", dut.state_q);
    end
    wait_ena();
    tests++; if (q !== 16'h8000) begin fails++; $display("FAIL rel_q_mid: got %h want 8000", q); end
  endtask

  task automatic test_retrigger();
    int n;
    do_reset();
    voiced = 1; gate = 1; pitch_inc = '0;
    n = 0;
    while (dut.env_q != 8'd60 && n < 200) begin wait_ena(); n++; end
    gate = 0;
    n = 0;
    while (dut.env_q != 8'd40 && n < 100) begin wait_ena(); n++; end
    gate = 1;
    for (int i = 0; i < 3; i++) begin
      wait_ena();
      tests++;
      if (dut.env_q !== 8'(40 + i)) begin
        fails++; $display("FAIL retrig_env%0d: got %0d want %0d", i, dut.env_q, 40 + i);
      end
      if (i == 0) begin
        tests++;
        if (dut.state_q !== ENV_ATTACK) begin
          fails++; $display("FAIL retrig_state: got %0d want ATTACK", dut.state_q);
        end
      end
    end
  endtask

  task automatic test_voiced_switch();
    int n;
    logic [15:0] exp;
    do_reset();
    voiced = 1; gate = 1; pitch_inc = '0;
    n = 0;
    while (dut.state_q != ENV_SUSTAIN && n < 300) begin wait_ena(); n++; end
    for (int i = 0; i < 3; i++) begin
      wait_ena(); n++;
      tests++;
      if (q !== 16'h0080) begin fails++; $display("FAIL zero_pitch_hold%0d: got %h want 0080", i, q); end
    end
    repeat (2) @(posedge clk);
    #1 voiced = 0;
    @(posedge clk); #1;
    tests++; if (q !== 16'h0080 || ena !== 1'b0) begin
      fails++; $display("FAIL voiced_between: got q %h ena %b want 0080/0", q, ena);
    end
    wait_ena(); n++;
    exp = scale_exp(lfsr_after(n - 1), 255);
    tests++; if (q !== exp) begin fails++; $display("FAIL noise_switch: got %h want %h", q, exp); end
    voiced = 1;
    wait_ena(); n++;
    tests++; if (q !== 16'h0080) begin fails++; $display("FAIL saw_return: got %h want 0080", q); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lfsr();
    test_attack_saw();
    test_release();
    test_retrigger();
    test_voiced_switch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
